// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Memory bus between the load/store unit (master) and memory (slave).
//   bus_req   : master -> slave, transfer request, held until bus_ack
//   bus_we    : master -> slave, 1 = write
//   bus_addr  : master -> slave, word-aligned byte address
//   bus_be    : master -> slave, byte enables (little-endian lanes)
//   bus_wdata : master -> slave, lane-replicated write data
//   bus_ack   : slave -> master, transfer complete, qualifies bus_rdata
//   bus_rdata : slave -> master, read data
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Converts a single load/store request into one memory bus transfer.
// Formats sub-word store data and byte enables, extracts and extends
// load data, detects misaligned/illegal accesses and bus timeouts.
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   start         : request strobe, only looked at in IDLE
//   MemRead/Write : load / store request (both set is illegal)
//   size          : 00 byte, 01 half, 10 word, 11 illegal
//   sign_ext      : loads only, 1 = sign-extend sub-word results
//   alu_output    : effective byte address
//   store_data    : store operand
//   bus           : memory bus (master side)
//   load_data     : extended load result (cleared on a fault)
//   done          : one-cycle completion pulse
//   busy          : high whenever not IDLE
//   fault         : one-cycle error pulse, coincident with done
module load_store_unit (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [1:0]               size,
    input  logic                     sign_ext,
    input  logic [31:0]              alu_output,
    input  logic [31:0]              store_data,
    load_store_unit_if.master        bus,
    output logic [31:0]              load_data,
    output logic                     done,
    output logic                     busy,
    output logic                     fault
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]  state;
    logic [3:0]  tmo_cnt;
    logic        we_q;
    logic        sx_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        illegal;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] rdata_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request decode and store formatting from the live inputs.
    always_comb begin
        illegal   = 1'b0;
        be_fmt    = 4'b0000;
        wdata_fmt = store_data;
        if (MemRead && MemWrite)
            illegal = 1'b1;
        case (size)
            2'b00: begin
                be_fmt    = 4'b0001 << alu_output[1:0];
                wdata_fmt = {4{store_data[7:0]}};
            end
            2'b01: begin
                if (alu_output[0])
                    illegal = 1'b1;
                be_fmt    = alu_output[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{store_data[15:0]}};
            end
            2'b10: begin
                if (alu_output[1:0] != 2'b00)
                    illegal = 1'b1;
                be_fmt    = 4'b1111;
                wdata_fmt = store_data;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Load extraction uses the latched offset/size so it stays valid for the whole REQ.
    always_comb begin
        rd_byte = bus.bus_rdata[7:0];
        case (off_q)
            2'b00:   rd_byte = bus.bus_rdata[7:0];
            2'b01:   rd_byte = bus.bus_rdata[15:8];
            2'b10:   rd_byte = bus.bus_rdata[23:16];
            default: rd_byte = bus.bus_rdata[31:24];
        endcase
        rd_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_q)
            2'b00:   rdata_ext = {{24{sx_q & rd_byte[7]}}, rd_byte};
            2'b01:   rdata_ext = {{16{sx_q & rd_half[15]}}, rd_half};
            default: rdata_ext = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            we_q      <= 1'b0;
            sx_q      <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (MemRead || MemWrite)) begin
                        if (illegal) begin
                            state     <= ERR;
                            load_data <= '0;
                        end else begin
                            state   <= REQ;
                            tmo_cnt <= '0;
                            we_q    <= MemWrite;
                            sx_q    <= sign_ext;
                            size_q  <= size;
                            off_q   <= alu_output[1:0];
                            be_q    <= be_fmt;
                            addr_q  <= {alu_output[31:2], 2'b00};
                            wdata_q <= wdata_fmt;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state <= DONE;
                        if (!we_q)
                            load_data <= rdata_ext;
                    end else if (tmo_cnt == 4'd15) begin
                        // 16th REQ cycle without ack
                        state     <= ERR;
                        load_data <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_req   = (state == REQ);
    assign bus.bus_we    = (state == REQ) && we_q;
    assign bus.bus_be    = (state == REQ) ? be_q : 4'b0000;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign done  = (state == DONE) || (state == ERR);
    assign fault = (state == ERR);
    assign busy  = (state != IDLE);

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- MemRead  in  1  load request
- MemWrite  in  1  store request
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends
- alu_output  in  32  effective byte address, from the ALU result
- store_data  in  32  store operand; low byte or half is used for sub-word stores
- bus_req  out  1  bus request
- bus_we  out  1  1 means write
- bus_addr  out  32  word address, {alu_output[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  write data, lane-replicated
- bus_ack  in  1  transfer complete; also qualifies bus_rdata
- bus_rdata  in  32  read data
- load_data  out  32  extended load result
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- fault  out  1  one-cycle pulse coincident with done on an error

Function
REQ-002 SHALL implement FSM states IDLE, REQ, DONE and ERR.
REQ-003 IDLE, on start with exactly one of MemRead/MemWrite set:
- legal access: latch address, size, sign_ext, direction and formatted write data; go to REQ.
- illegal access: go to ERR.
REQ-004 An access SHALL be illegal when any of these holds:
- size=11
- size=01 with alu_output[0]=1
- size=10 with alu_output[1:0]!=00
- MemRead and MemWrite both set
REQ-005 In IDLE, start with neither MemRead nor MemWrite set SHALL be ignored, with no state change.
REQ-006 In IDLE, start SHALL be ignored when busy; there is no queuing.
REQ-007 In REQ, bus_req=1 and bus_addr/bus_we/bus_be/bus_wdata SHALL hold stable until bus_ack is sampled high.
REQ-008 bus_req SHALL first assert on the cycle after start was sampled; REQ SHALL last at least one cycle.
REQ-009 bus_ack sampled in REQ SHALL move the FSM to DONE; loads SHALL register load_data from bus_rdata on that same edge.
REQ-010 bus_ack outside REQ SHALL be ignored.
REQ-011 A 4-bit timeout counter SHALL clear on REQ entry and increment each REQ cycle without ack; on 16 cycles without ack the FSM SHALL go to ERR and drop bus_req.
REQ-012 DONE SHALL last one cycle: done=1, then IDLE.
REQ-013 ERR SHALL last one cycle: done=1, fault=1, load_data=0, then IDLE.
REQ-014 Minimum latency: start at edge N, bus_ack high during cycle N+1, done high in cycle N+2.
REQ-015 Byte enables and write data, little-endian with k = alu_output[1:0]:
- byte: bus_be = 4'b0001<<k; bus_wdata = store_data[7:0] replicated to all four lanes.
- half: bus_be = 0011 when k=00, 1100 when k=10; bus_wdata = {store_data[15:0], store_data[15:0]}.
- word: bus_be = 1111; bus_wdata = store_data.
REQ-016 Load extraction: byte from bus_rdata[8k+7:8k]; half from [15:0] or [31:16]; each extended to 32 bits per sign_ext; word loads ignore sign_ext.
REQ-017 Stores SHALL leave load_data unchanged.
REQ-018 bus_req, bus_we, bus_be SHALL be 0 outside REQ; bus_addr and bus_wdata SHALL hold their last values.

Reset
REQ-019 On rst sampled high, the next state SHALL be IDLE, and bus_req, bus_we, bus_be, done, fault, busy SHALL be 0.
REQ-020 On rst sampled high, load_data, bus_addr, bus_wdata and the timeout counter SHALL be 0.
REQ-021 rst sampled high SHALL take priority over start and bus_ack on the same edge.
REQ-022 rst during REQ SHALL abort the transfer: bus_req drops on that edge, and no done or fault pulse follows.

Verification
REQ-023 lb: addr 0x1003, sign_ext=1, bus_rdata 0x80FF_FF7F, ack at first REQ cycle:
- bus_addr 0x1000, bus_be 1000
- load_data 0xFFFF_FF80, done in cycle N+2
REQ-024 sh: addr 0x2002, store_data 0x1234_ABCD, ack after 3 cycles:
- bus_be 1100, bus_wdata 0xABCD_ABCD, bus_we=1
- request held stable for 3 cycles; load_data unchanged
REQ-025 lw at addr 0x0000_0006 -> no bus_req; done=fault=1 in cycle N+1; load_data=0.
REQ-026 lw, bus_ack never asserted -> bus_req high exactly 16 cycles, then a done+fault pulse.
REQ-027 Reset mid-operation and start-while-busy:
- rst asserted in second REQ cycle -> bus_req=0 next cycle; no done; busy=0.
- start pulsed while busy -> ignored.
REQ-028 lhu at addr 0x10, bus_rdata 0x0000_8001 -> load_data 0x0000_8001.
REQ-029 lbu at addr 0x11, bus_rdata 0x0000_8001 -> load_data 0x0000_0080.
